// File: rtl/regfile_ctrl_pkg.sv
// Shared types for the register-file command sequencer: command opcodes and
// the step states that map one-to-one onto register-file strobes.
package regfile_ctrl_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_LDA = 3'b000,
    OP_STA = 3'b001,
    OP_MOV = 3'b010,
    OP_SWP = 3'b011,
    OP_CLR = 3'b100
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LD_B = 3'd1,
    S_ST_A = 3'd2,
    S_LD_T = 3'd3,
    S_ST_B = 3'd4,
    S_LD_S = 3'd5,
    S_CLR  = 3'd6
  } state_e;

endpackage

// File: rtl/regfile_ctrl.sv
// Command sequencer in front of the accumulator register file. Each accepted
// command is expanded into a short run of single-strobe steps (acc write,
// acc-to-register set, clear-all). The accumulator value and the first
// operand are snapshotted at accept so MOV/SWP can restore/exchange through
// the accumulator without a spare register.
module regfile_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int pw = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OP_W-1:0] cmd_op,
  input  logic [pw-1:0]   cmd_ra,
  input  logic [pw-1:0]   cmd_rb,
  output logic            done,
  output logic            rf_regWrite,
  output logic            rf_regSet,
  output logic            rf_reset,
  output logic [7:0]      rf_writeData,
  output logic [pw:0]     rf_opRegAddr,
  input  logic [7:0]      rf_accData,
  input  logic [7:0]      rf_opRegData
);

  state_e          state;
  state_e          next_state;
  state_e          first_state;
  logic [7:0]      save;
  logic [7:0]      tmp;
  logic [pw-1:0]   a_q;
  logic [pw-1:0]   b_q;
  logic [pw-1:0]   a_n;
  logic [pw-1:0]   b_n;
  logic [OP_W-1:0] op_q;
  logic            full_q;
  logic            full_n;
  logic [pw-1:0]   addr;
  logic            accept;
  logic            ra_zero;
  logic            rb_zero;
  logic            rab_eq;

  assign cmd_ready    = (state == S_IDLE);
  assign accept       = cmd_valid && cmd_ready;
  assign ra_zero      = (cmd_ra == '0);
  assign rb_zero      = (cmd_rb == '0);
  assign rab_eq       = (cmd_ra == cmd_rb);
  assign rf_opRegAddr = {1'b0, addr};

  // Sequence lookup: first step and normalized operands for the offered command.
  // full_n marks MOV/SWP with two distinct nonzero operands (the long forms).
  always_comb begin
    first_state = S_IDLE;
    a_n         = cmd_ra;
    b_n         = cmd_rb;
    full_n      = 1'b0;
    case (cmd_op)
      OP_LDA: begin
        first_state = S_LD_B;
        b_n         = cmd_ra;
      end
      OP_STA: first_state = S_ST_A;
      OP_MOV: begin
        if (!rab_eq) begin
          if (ra_zero) begin
            first_state = S_LD_B;
          end else if (rb_zero) begin
            first_state = S_ST_A;
          end else begin
            first_state = S_LD_B;
            full_n      = 1'b1;
          end
        end
      end
      OP_SWP: begin
        if (!rab_eq) begin
          if (ra_zero || rb_zero) begin
            // Exchange acc with the nonzero register: set it, then reload acc.
            first_state = S_ST_A;
            a_n         = ra_zero ? cmd_rb : cmd_ra;
          end else begin
            first_state = S_LD_B;
            full_n      = 1'b1;
          end
        end
      end
      OP_CLR: first_state = S_CLR;
      default: first_state = S_IDLE;
    endcase
  end

  // State register and registered completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      done  <= ((state != S_IDLE) && (next_state == S_IDLE)) ||
               (accept && (first_state == S_IDLE));
    end
  end

  // Snapshot accumulator, first operand and normalized pointers at accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      save   <= '0;
      tmp    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      full_q <= 1'b0;
    end else if (accept) begin
      save   <= rf_accData;
      tmp    <= rf_opRegData;
      a_q    <= a_n;
      b_q    <= b_n;
      op_q   <= cmd_op;
      full_q <= full_n;
    end
  end

  // Next-state and per-step strobe decode; exactly one strobe per busy state.
  always_comb begin
    next_state   = state;
    rf_regWrite  = 1'b0;
    rf_regSet    = 1'b0;
    rf_reset     = 1'b0;
    rf_writeData = '0;
    addr         = '0;
    case (state)
      S_IDLE: begin
        // Point the read port at the operand whose value tmp must capture.
        addr = ((cmd_op == OP_SWP) && ra_zero) ? cmd_rb : cmd_ra;
        if (accept) next_state = first_state;
      end
      S_LD_B: begin
        rf_regWrite  = 1'b1;
        addr         = b_q;
        rf_writeData = rf_opRegData;
        next_state   = full_q ? S_ST_A : S_IDLE;
      end
      S_ST_A: begin
        rf_regSet = 1'b1;
        addr      = a_q;
        if (op_q == OP_SWP) next_state = S_LD_T;
        else if (full_q)    next_state = S_LD_S;
        else                next_state = S_IDLE;
      end
      S_LD_T: begin
        rf_regWrite  = 1'b1;
        rf_writeData = tmp;
        next_state   = full_q ? S_ST_B : S_IDLE;
      end
      S_ST_B: begin
        rf_regSet  = 1'b1;
        addr       = b_q;
        next_state = S_LD_S;
      end
      S_LD_S: begin
        rf_regWrite  = 1'b1;
        rf_writeData = save;
        next_state   = S_IDLE;
      end
      S_CLR: begin
        rf_reset   = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: includes a 16x8 accumulator register file model,
// a command-level reference of register contents and a scoreboard of
// expected strobe sequences.
module tb_regfile_ctrl;
  import regfile_ctrl_pkg::*;

  localparam int PW = 4;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [PW-1:0] cmd_ra;
  logic [PW-1:0] cmd_rb;
  logic          done;
  logic          rf_regWrite;
  logic          rf_regSet;
  logic          rf_reset;
  logic [7:0]    rf_writeData;
  logic [PW:0]   rf_opRegAddr;
  logic [7:0]    rf_accData;
  logic [7:0]    rf_opRegData;

  logic [7:0]    rf    [16];
  logic [7:0]    ref_r [16];
  logic          load_en;
  logic [3:0]    load_idx;
  logic [7:0]    load_val;

  int n_tests;
  int n_fail;

  typedef struct {
    string      tag;
    logic [2:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [19:0] tr;
    int         len;
  } exp_t;

  exp_t sb[$];

  regfile_ctrl #(.pw(PW)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_ra       (cmd_ra),
    .cmd_rb       (cmd_rb),
    .done         (done),
    .rf_regWrite  (rf_regWrite),
    .rf_regSet    (rf_regSet),
    .rf_reset     (rf_reset),
    .rf_writeData (rf_writeData),
    .rf_opRegAddr (rf_opRegAddr),
    .rf_accData   (rf_accData),
    .rf_opRegData (rf_opRegData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model (backdoor load port used only while the controller idles).
  always_ff @(posedge clk) begin
    if (load_en) rf[load_idx] <= load_val;
    else if (rf_reset) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
    end else if (rf_regWrite) rf[0] <= rf_writeData;
    else if (rf_regSet) rf[rf_opRegAddr[3:0]] <= rf[0];
  end

  assign rf_accData   = rf[0];
  assign rf_opRegData = rf[rf_opRegAddr[3:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected strobe trace: 2-bit code per step, 1=acc write, 2=set, 3=clear.
  function automatic void exp_seq(input logic [2:0] op, input logic [3:0] ra,
                                  input logic [3:0] rb, output logic [19:0] tr,
                                  output int len);
    int codes[$];
    codes = {};
    case (op)
      3'b000: codes = {1};
      3'b001: codes = {2};
      3'b010: begin
        if (ra == rb) codes = {};
        else if (ra == 0) codes = {1};
        else if (rb == 0) codes = {2};
        else codes = {1, 2, 1};
      end
      3'b011: begin
        if (ra == rb) codes = {};
        else if (ra == 0 || rb == 0) codes = {2, 1};
        else codes = {1, 2, 1, 2, 1};
      end
      3'b100: codes = {3};
      default: codes = {};
    endcase
    tr  = '0;
    len = codes.size();
    foreach (codes[i]) tr = (tr << 2) | 20'(codes[i]);
  endfunction

  task automatic push_exp(input string tag, input logic [2:0] op,
                          input logic [3:0] ra, input logic [3:0] rb);
    exp_t e;
    e.tag = tag;
    e.op  = op;
    e.ra  = ra;
    e.rb  = rb;
    exp_seq(op, ra, rb, e.tr, e.len);
    sb.push_back(e);
  endtask

  // Command-level effect on register contents.
  task automatic apply_ref(input exp_t e);
    logic [7:0] t;
    case (e.op)
      3'b000: ref_r[0] = ref_r[e.ra];
      3'b001: ref_r[e.ra] = ref_r[0];
      3'b010: if (e.ra != e.rb) ref_r[e.ra] = ref_r[e.rb];
      3'b011: begin
        t = ref_r[e.ra];
        ref_r[e.ra] = ref_r[e.rb];
        ref_r[e.rb] = t;
      end
      3'b100: for (int i = 0; i < 16; i++) ref_r[i] = 8'h00;
      default: ;
    endcase
  endtask

  task automatic compare_rf(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_r%0d", tag, i), 32'(rf[i]), 32'(ref_r[i]));
  endtask

  task automatic poke(input logic [3:0] idx, input logic [7:0] val);
    @(negedge clk);
    load_en  = 1'b1;
    load_idx = idx;
    load_val = val;
    @(posedge clk);
    #1;
    load_en    = 1'b0;
    ref_r[idx] = val;
  endtask

  // Called at the negedge of the first cycle after accept; returns at the
  // negedge of the done cycle.
  task automatic wait_done(input string tag);
    logic [19:0] tr;
    int          len;
    bit          got;
    logic [1:0]  code;
    exp_t        e;
    tr  = '0;
    len = 0;
    got = 1'b0;
    for (int c = 1; c <= 12 && !got; c++) begin
      if (c > 1) @(negedge clk);
      check({tag, "_onehot"}, 32'($countones({rf_regWrite, rf_regSet, rf_reset}) <= 1), 32'd1);
      check({tag, "_addr_msb"}, 32'(rf_opRegAddr[PW]), 32'd0);
      if (!rf_regWrite) check({tag, "_wd_zero"}, 32'(rf_writeData), 32'd0);
      code = rf_reset ? 2'd3 : rf_regSet ? 2'd2 : rf_regWrite ? 2'd1 : 2'd0;
      if (done) begin
        got = 1'b1;
        check({tag, "_ready_at_done"}, 32'(cmd_ready), 32'd1);
        check({tag, "_idle_strobes"}, 32'(code), 32'd0);
      end else begin
        check({tag, "_busy_ready"}, 32'(cmd_ready), 32'd0);
        tr = (tr << 2) | 20'(code);
        len++;
      end
    end
    if (!got) check({tag, "_done_timeout"}, 32'(done), 32'd1);
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_steps"}, 32'(len), 32'(e.len));
      check({tag, "_trace"}, 32'(tr), 32'(e.tr));
      apply_ref(e);
      compare_rf(tag);
    end
  endtask

  task automatic run_cmd(input string tag, input logic [2:0] op,
                         input logic [3:0] ra, input logic [3:0] rb);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_ra    = ra;
    cmd_rb    = rb;
    check({tag, "_ready_pre"}, 32'(cmd_ready), 32'd1);
    push_exp(tag, op, ra, rb);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_ra    = '0;
    cmd_rb    = '0;
    load_en   = 1'b0;
    load_idx  = '0;
    load_val  = '0;
    #2 reset = 1'b1;

    // Reset state and register preload.
    for (int i = 0; i < 16; i++) poke(4'(i), 8'(i));
    poke(4'd1, 8'h11);
    poke(4'd3, 8'hA5);
    poke(4'd7, 8'h3C);
    poke(4'd8, 8'h22);
    poke(4'd9, 8'h99);
    @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_strobes", 32'({rf_regWrite, rf_regSet, rf_reset}), 32'd0);
    check("rst_wd", 32'(rf_writeData), 32'd0);
    reset = 1'b0;

    // Accumulator preload through the controller.
    run_cmd("lda1", OP_LDA, 4'd1, 4'd0);
    run_cmd("sta2", OP_STA, 4'd2, 4'd0);
    check("pre_r0", 32'(rf[0]), 32'h11);

    // Main sequences.
    run_cmd("swp37", OP_SWP, 4'd3, 4'd7);
    check("swp37_r3", 32'(rf[3]), 32'h3C);
    check("swp37_r7", 32'(rf[7]), 32'hA5);
    run_cmd("mov53", OP_MOV, 4'd5, 4'd7);
    check("mov53_r5", 32'(rf[5]), 32'hA5);
    check("mov53_r0", 32'(rf[0]), 32'h11);

    // Edge operands.
    run_cmd("lda8", OP_LDA, 4'd8, 4'd0);
    run_cmd("swp09", OP_SWP, 4'd0, 4'd9);
    check("swp09_r0", 32'(rf[0]), 32'h99);
    check("swp09_r9", 32'(rf[9]), 32'h22);
    run_cmd("swp60", OP_SWP, 4'd6, 4'd0);
    run_cmd("mov44", OP_MOV, 4'd4, 4'd4);
    run_cmd("mov03", OP_MOV, 4'd0, 4'd3);
    run_cmd("mov40", OP_MOV, 4'd4, 4'd0);
    run_cmd("ill5", 3'd5, 4'd2, 4'd3);
    run_cmd("ill7", 3'd7, 4'd1, 4'd0);

    // Back-to-back LDA r3 / STA r6 with cmd_valid held.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_LDA;
    cmd_ra    = 4'd3;
    push_exp("b2b_lda", OP_LDA, 4'd3, 4'd0);
    @(posedge clk);
    @(negedge clk);
    cmd_op = OP_STA;
    cmd_ra = 4'd6;
    wait_done("b2b_lda");
    push_exp("b2b_sta", OP_STA, 4'd6, 4'd0);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done("b2b_sta");
    check("b2b_r6", 32'(rf[6]), 32'(rf[3]));

    // CLR with a command held valid while busy.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_CLR;
    push_exp("clr", OP_CLR, 4'd0, 4'd0);
    @(posedge clk);
    @(negedge clk);
    cmd_op = OP_MOV;
    cmd_ra = 4'd2;
    cmd_rb = 4'd3;
    wait_done("clr");
    push_exp("held_mov", OP_MOV, 4'd2, 4'd3);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done("held_mov");

    // Reset during the ST_A step of a full SWP.
    poke(4'd0, 8'h11);
    poke(4'd3, 8'hA5);
    poke(4'd7, 8'h3C);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_SWP;
    cmd_ra    = 4'd3;
    cmd_rb    = 4'd7;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("abort_ldb", 32'(rf_regWrite), 32'd1);
    @(negedge clk);
    check("abort_sta", 32'(rf_regSet), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_async_ready", 32'(cmd_ready), 32'd1);
    check("abort_async_strobes", 32'({rf_regWrite, rf_regSet, rf_reset}), 32'd0);
    @(negedge clk);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_strobes", 32'({rf_regWrite, rf_regSet, rf_reset}), 32'd0);
    reset = 1'b0;
    ref_r[0] = ref_r[7];
    compare_rf("abort");

    // Normal operation resumes after the abort.
    run_cmd("post_lda3", OP_LDA, 4'd3, 4'd0);
    check("post_r0", 32'(rf[0]), 32'hA5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
